// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types and constants.
// State encoding, default tohost address and the pass code.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TMO
  } state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam logic [31:0] PASS_CODE       = 32'd1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: core reset stretch, run counters, tohost/timeout verdict.
// Define RUN_CTRL_SIM_STOP_EN to print the verdict and $stop (sim only).
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                RST_CYCLES     = 10,
  parameter int                TIMEOUT_CYCLES = 50,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEF),
  parameter int                CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              core_rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              retire,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [30:0]       fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          tmo_q, tmo_d;
  logic [30:0]   fc_q, fc_d;

  logic run, term, is_pass, tmo_hit;

  assign run     = (state_q == ST_RUN);
  assign term    = run && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
  assign is_pass = (st_data == PASS_CODE);
  assign tmo_hit = run && TMO_EN && (cycle_cnt == TMO_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fc_d    = fc_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      ST_RUN: begin
        // a terminating store beats a same-cycle timeout
        if (term) begin
          state_d = is_pass ? ST_PASS : ST_FAIL;
          if (!is_pass) fc_d = st_data[31:1];
        end else if (tmo_hit) begin
          state_d = ST_TMO;
        end
      end
      default: ;
    endcase
    done_d     = (state_d == ST_PASS) || (state_d == ST_FAIL) ||
                 (state_d == ST_TMO);
    pass_d     = (state_d == ST_PASS);
    tmo_d      = (state_d == ST_TMO);
    core_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      hold_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      fc_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      fc_q       <= fc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (run),
    .cnt_o (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ret (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (run && retire),
    .cnt_o (instret_cnt)
  );

  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = tmo_q;
  assign fail_code = fc_q;

`ifdef RUN_CTRL_SIM_STOP_EN
  logic disp_q, stop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      disp_q <= done_d && !done_q;
      stop_q <= disp_q;
      if (disp_q)
        $display("run_ctrl: pass=%0b timeout=%0b cycles=%0d instret=%0d code=%0d",
                 pass_q, tmo_q, cycle_cnt, instret_cnt, fc_q);
      if (stop_q) $stop;
    end
  end
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl against a cycle-level behavioural model.
// Directed scenarios followed by randomized runs.
module tb_run_ctrl;

  localparam int          RC = 10;
  localparam int          TO = 50;
  localparam logic [31:0] TH = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, st_valid, retire;
  logic [31:0] st_addr, st_data;
  logic        core_rst, done, pass, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  run_ctrl #(
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO), .ADDR_W(32),
    .TOHOST_ADDR(TH), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .core_rst(core_rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .retire(retire), .done(done), .pass(pass), .timeout(timeout),
    .fail_code(fail_code), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: edges since reset release, run counters, verdict
  int          m_edges, m_cyc, m_inst;
  bit          m_end, m_pass, m_tmo;
  logic [30:0] m_fc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_edges = 0; m_cyc = 0; m_inst = 0;
      m_end = 0; m_pass = 0; m_tmo = 0; m_fc = '0;
    end else if (m_end) begin
    end else if (m_edges < RC) begin
      m_edges++;
    end else begin
      int pre = m_cyc;
      m_cyc++;
      if (retire) m_inst++;
      if (st_valid && st_addr == TH && st_data[0]) begin
        m_end = 1;
        if (st_data == 32'd1) m_pass = 1;
        else                  m_fc = st_data[31:1];
      end else if (TO != 0 && pre == TO - 1) begin
        m_end = 1;
        m_tmo = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("core_rst", core_rst, !(m_edges >= RC && !m_end));
    chk("done", done, m_end);
    chk("pass", pass, m_pass);
    chk("timeout", timeout, m_tmo);
    chk("fail_code", fail_code, m_fc);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instret_cnt", instret_cnt, m_inst);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; st_valid = 0; retire = 0;
    st_addr = TH + 32'd4; st_data = 32'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1; st_addr = a; st_data = d;
    step();
    st_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
    repeat (RC) step();
  endtask

  task automatic measure_fall(input string tag);
    int fall = -1;
    for (int i = 1; i <= RC + 2; i++) begin
      step();
      if (fall < 0 && !core_rst) fall = i;
    end
    chk(tag, fall, RC);
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (5) step();
    chk("reset_core_rst", core_rst, 1);
    chk("reset_cycle", cycle_cnt, 0);
    rst = 0;
    measure_fall("hold_len");

    // pass after 20 cycles with 7 retires
    begin
      bit [19:0] pat = '0;
      do_reset();
      while ($countones(pat) < 7) pat[$urandom_range(19, 0)] = 1'b1;
      for (int i = 0; i < 20; i++) begin
        retire   = pat[i];
        st_valid = $urandom_range(1, 0);
        st_addr  = TH + 32'd4 * $urandom_range(100, 1);
        st_data  = $urandom;
        step();
      end
      idle();
      store(TH, 32'd1);
      chk("p_done", done, 1);
      chk("p_pass", pass, 1);
      chk("p_instret", instret_cnt, 7);
      chk("p_core_rst", core_rst, 1);
      repeat (3) begin
        retire = 1;
        step();
      end
      idle();
    end

    // fail code, later pass store ignored
    do_reset();
    repeat (4) step();
    store(TH, 32'h0000_0007);
    chk("f_done", done, 1);
    chk("f_pass", pass, 0);
    chk("f_code", fail_code, 3);
    store(TH, 32'd1);
    chk("f_sticky", pass, 0);

    // even value and wrong address ignored, then timeout
    do_reset();
    store(TH, 32'd2);
    store(TH + 32'd4, 32'd1);
    chk("ign_done", done, 0);
    begin
      int n = 0;
      while (!done && n < 100) begin
        step();
        n++;
      end
      chk("t_bounded", n < 100, 1);
    end
    chk("t_timeout", timeout, 1);
    chk("t_cycles", cycle_cnt, TO);

    // store on the last cycle beats timeout
    do_reset();
    repeat (TO - 1) step();
    store(TH, 32'd1);
    chk("race_pass", pass, 1);
    chk("race_tmo", timeout, 0);
    chk("race_cyc", cycle_cnt, TO);

    // reset mid-run
    do_reset();
    repeat (30) step();
    chk("mid_cyc", cycle_cnt, 30);
    rst = 1;
    step();
    chk("mid_core_rst", core_rst, 1);
    chk("mid_cyc0", cycle_cnt, 0);
    rst = 0;
    measure_fall("mid_hold_len");

    // randomized runs
    for (int it = 0; it < 40; it++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        int sel = $urandom_range(2, 0);
        retire   = $urandom_range(1, 0);
        st_valid = ($urandom_range(5, 0) == 0);
        st_addr  = ($urandom_range(2, 0) == 0) ? TH : TH + 32'd4;
        st_data  = (sel == 0) ? 32'd1 :
                   (sel == 1) ? ($urandom | 32'd1) : ($urandom & ~32'd1);
        rst      = ($urandom_range(150, 0) == 0);
        step();
      end
      idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller for the RISC-V SOPC simulation and bring-up environment. It sits between the bench or board clock/reset and the `sopc` core. It stretches the top-level reset into a configurable core-reset pulse, then counts cycles and retired instructions. It ends the run on a `tohost` store (pass or fail code) or on a cycle-count timeout. It replaces the fixed `#195` reset and `#1000 $stop` timing with parameters and a pass/fail verdict.

## Interface
Parameters:
- `RST_CYCLES`, 10: cycles `core_rst` stays high after `rst` falls; must be ≥1.
- `TIMEOUT_CYCLES`, 50: run-cycle limit; 0 disables the timeout.
- `ADDR_W`, 32: width of the monitored store address.
- `TOHOST_ADDR`, 32'h0000_1000: address of the `tohost` word.
- `CNT_W`, 32: width of the cycle and instret counters.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `core_rst`, out, 1: reset to the `sopc` core, active-high.
- `st_valid`, in, 1: the core's data-memory store is committing this cycle.
- `st_addr`, in, ADDR_W: store byte address.
- `st_data`, in, 32: store data.
- `retire`, in, 1: one instruction retired this cycle.
- `done`, out, 1: run ended, sticky.
- `pass`, out, 1: run ended with `tohost`==1.
- `timeout`, out, 1: run ended by timeout.
- `fail_code`, out, 31: `st_data[31:1]` of a failing `tohost` store; 0 otherwise.
- `cycle_cnt`, out, CNT_W: cycles spent in RUN.
- `instret_cnt`, out, CNT_W: instructions retired in RUN.

## Operation
- FSM states: HOLD, RUN, PASS, FAIL, TMO.
- Reset (`rst`=1 at an edge):
  - state goes to HOLD and the hold counter to 0.
  - `core_rst`=1.
  - `done`, `pass`, `timeout`, `fail_code`, `cycle_cnt` and `instret_cnt` all go to 0.
- HOLD:
  - the hold counter increments on each edge with `rst`=0.
  - when it equals `RST_CYCLES`-1, the next state is RUN and `core_rst` becomes 0.
- RUN, each cycle:
  - `cycle_cnt` increments and saturates at all-ones.
  - `instret_cnt` increments if `retire` is high; it also saturates.
- A `tohost` store is `st_valid` && `st_addr`==`TOHOST_ADDR`. Only stores with `st_data[0]`=1 end the run; even values are ignored.
  - `st_data`==1: go to PASS.
  - Other odd `st_data`: go to FAIL and latch `fail_code`=`st_data[31:1]`.
- Timeout: in RUN, when `TIMEOUT_CYCLES`≠0 and `cycle_cnt`==`TIMEOUT_CYCLES`-1 with no terminating store that cycle, go to TMO.
- Simultaneous events: a terminating store and the timeout on the same cycle resolve to PASS or FAIL; the store wins.
- Terminal states (PASS, FAIL, TMO):
  - sticky until `rst`.
  - `core_rst` is re-asserted to freeze the core.
  - counters hold their values and later inputs are ignored.
- Reset mid-run: an `rst` pulse in any state restarts from HOLD with all outputs cleared.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `core_rst` falls exactly `RST_CYCLES` edges after the first edge sampling `rst`=0.
- The first RUN cycle is the first edge with `core_rst`=0; after that edge `cycle_cnt`=1.
- Verdict latency: `done` plus `pass`/`timeout`/`fail_code` assert one edge after the qualifying store is sampled, all on the same edge.
- `core_rst` rises on that same edge.
- A `retire` on the terminating cycle is counted.

## Configuration
- `RUN_CTRL_SIM_STOP_EN` defined:
  - on entry to a terminal state, `$display` the verdict, `cycle_cnt`, `instret_cnt` and `fail_code`.
  - then `$stop` on the next edge.
  - the block is non-synthesizable in this mode.
- Undefined: no system tasks; the block reports through its output flags only and is synthesizable.

## Structure
- Shared package `run_ctrl_pkg`:
  - state enum (HOLD/RUN/PASS/FAIL/TMO).
  - default `TOHOST_ADDR`.
  - the PASS_CODE=1 constant.
- One natural sub-module: `sat_counter` (CNT_W, enable, sync clear, saturating), instantiated for `cycle_cnt` and `instret_cnt`.
- FSM and hold counter stay in `run_ctrl`.

## Test plan
- `RST_CYCLES`=10, `rst` high for 5 cycles then low → `core_rst` falls on exactly the 10th edge after `rst` falls; `cycle_cnt`=0 until then.
- RUN, `retire` on 7 of 20 cycles, then store 1 to `TOHOST_ADDR` → next edge: `done`=1, `pass`=1, `instret_cnt`=7, `core_rst`=1.
- Store 32'h0000_0007 to `TOHOST_ADDR` → `done`=1, `pass`=0, `fail_code`=3. A later store of 1 is ignored.
- Store 2 to `TOHOST_ADDR`, then 1 to `TOHOST_ADDR`+4 → no termination.
- `TIMEOUT_CYCLES`=50, no stores → `timeout`=1 with `cycle_cnt`=50.
- Store 1 on the 50th RUN cycle → `pass`=1 and `timeout`=0.
- `rst` pulsed for 1 cycle while in RUN at `cycle_cnt`=30 → all outputs 0 and `core_rst`=1; run restarts with a full `RST_CYCLES` hold.
